// File: rtl/ahb_slave_fifo_pkg.sv
// Shared constants, pointer-width helper and the status bundle for the AHB slave FIFOs.
package ahb_slave_fifo_pkg;

   localparam int unsigned FIFO_DATA_W    = 32;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

   // Pointer width for a given depth (ceil(log2(depth))).
   function automatic int unsigned clog2_ptr(input int unsigned depth);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((33'(1) << i) < 33'(depth)) r = i + 1;
      end
      return r;
   endfunction

   // Status flags exported to the register file.
   typedef struct packed {
      logic wrfull;
      logic wralmost_full;
      logic rdempty;
      logic ovf;
      logic udf;
   } fifo_status_t;

endpackage

// File: rtl/fifo_regarray.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Contents are never reset.
module fifo_regarray
   import ahb_slave_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [clog2_ptr(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [clog2_ptr(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]             rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   // Show-ahead read
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_slave_fifo.sv
// Synchronous show-ahead FIFO between the AHB slave and user logic.
// Ports: clk, reset_n (sync, active-low); write side wrreq/wdata/wrfull/wralmost_full;
// read side rdack/rdata/rdempty; usedw occupancy; sticky ovf/udf cleared by clr_err.
module ahb_slave_fifo
   import ahb_slave_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = FIFO_DATA_W,
   parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
   parameter int unsigned AFULL_LVL = 12
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        wrreq,
   input  logic [DATA_W-1:0]           wdata,
   output logic                        wrfull,
   output logic                        wralmost_full,
   input  logic                        rdack,
   output logic [DATA_W-1:0]           rdata,
   output logic                        rdempty,
   output logic [clog2_ptr(DEPTH):0]   usedw,
   output logic                        ovf,
   output logic                        udf,
   input  logic                        clr_err
);

   localparam int unsigned PTR_W = clog2_ptr(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  usedw_q, usedw_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              wr_ok_c, rd_ok_c, we_c;
   logic [DATA_W-1:0] head_c;
   fifo_status_t      status_c;

   // Storage
   fifo_regarray #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_regarray (
      .clk   (clk),
      .we    (we_c),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr_q),
      .rdata (head_c)
   );

   // Flags decode from registered state only; accept and next-state logic
   always_comb begin
      status_c               = '0;
      status_c.wrfull        = (usedw_q == CNT_W'(DEPTH));
      status_c.wralmost_full = (usedw_q >= CNT_W'(AFULL_LVL));
      status_c.rdempty       = (usedw_q == '0);
      status_c.ovf           = ovf_q;
      status_c.udf           = udf_q;

      wr_ok_c  = wrreq & ~status_c.wrfull;
      rd_ok_c  = rdack & ~status_c.rdempty;
      // A write coinciding with reset must not touch storage
      we_c     = wr_ok_c & reset_n;

      wr_ptr_d = wr_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      usedw_d  = usedw_q + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
      // A new error wins over a simultaneous clear
      ovf_d    = (ovf_q & ~clr_err) | (wrreq & status_c.wrfull);
      udf_d    = (udf_q & ~clr_err) | (rdack & status_c.rdempty);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign wrfull        = status_c.wrfull;
   assign wralmost_full = status_c.wralmost_full;
   assign rdempty       = status_c.rdempty;
   assign ovf           = status_c.ovf;
   assign udf           = status_c.udf;
   assign usedw         = usedw_q;
   // Head word is hidden while empty
   assign rdata         = status_c.rdempty ? '0 : head_c;

endmodule

// File: tb/tb_ahb_slave_fifo.sv
// Scoreboard bench for ahb_slave_fifo with directed vectors.
module tb_ahb_slave_fifo;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wrreq;
   logic [31:0] wdata;
   logic        wrfull;
   logic        wralmost_full;
   logic        rdack;
   logic [31:0] rdata;
   logic        rdempty;
   logic [4:0]  usedw;
   logic        ovf;
   logic        udf;
   logic        clr_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_w;
   int          m_cnt = 0;
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;
   logic        max_used_ok;

   ahb_slave_fifo #(
      .DATA_W    (32),
      .DEPTH     (16),
      .AFULL_LVL (12)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .wrreq         (wrreq),
      .wdata         (wdata),
      .wrfull        (wrfull),
      .wralmost_full (wralmost_full),
      .rdack         (rdack),
      .rdata         (rdata),
      .rdempty       (rdempty),
      .usedw         (usedw),
      .ovf           (ovf),
      .udf           (udf),
      .clr_err       (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare the head word against the scoreboard on every successful pop
   always @(negedge clk) begin
      if (reset_n && rdack && !rdempty) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_pop: got 0x%08h expected no data", rdata);
         end else begin
            exp_w = exp_q.pop_front();
            chk("sb_rdata", rdata, exp_w);
         end
      end
   end

   // Drive one cycle, update the reference occupancy/flag model, then check status
   task automatic step(input logic rst, input logic wr, input logic [31:0] d,
                       input logic rd, input logic clr);
      logic w_ok, r_ok;
      reset_n = rst; wrreq = wr; wdata = d; rdack = rd; clr_err = clr;
      if (!rst) begin
         exp_q.delete();
         m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         w_ok  = wr && (m_cnt != 16);
         r_ok  = rd && (m_cnt != 0);
         m_ovf = (m_ovf && !clr) || (wr && m_cnt == 16);
         m_udf = (m_udf && !clr) || (rd && m_cnt == 0);
         if (w_ok) exp_q.push_back(d);
         m_cnt = m_cnt + int'(w_ok) - int'(r_ok);
      end
      @(posedge clk); #1;
      chk("usedw",   32'(usedw),         32'(m_cnt));
      chk("rdempty", 32'(rdempty),       32'(m_cnt == 0));
      chk("wrfull",  32'(wrfull),        32'(m_cnt == 16));
      chk("afull",   32'(wralmost_full), 32'(m_cnt >= 12));
      chk("ovf",     32'(ovf),           32'(m_ovf));
      chk("udf",     32'(udf),           32'(m_udf));
      if (m_cnt == 0) chk("rdata_zero_empty", rdata, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0; wrreq = 1'b0; wdata = '0; rdack = 1'b0; clr_err = 1'b0;

      // Reset then idle
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rst_rdempty", 32'(rdempty), 32'd1);
      chk("rst_usedw",   32'(usedw),   32'd0);
      chk("rst_rdata",   rdata,        32'h0);
      step(1, 0, 0, 0, 0);

      // Fill: almost-full at 12, full at 16
      for (int i = 0; i < 16; i++) begin
         step(1, 1, 32'h8000_0000 + 32'(i), 0, 0);
         if (i == 10) chk("afull_at_11", 32'(wralmost_full), 32'd0);
         if (i == 11) chk("afull_at_12", 32'(wralmost_full), 32'd1);
      end
      chk("full_at_16", 32'(wrfull), 32'd1);
      chk("head_first", rdata, 32'h8000_0000);

      // Overflow, then clear
      step(1, 1, 32'hDEAD_BEEF, 0, 0);
      chk("ovf_set",   32'(ovf),   32'd1);
      chk("ovf_usedw", 32'(usedw), 32'd16);
      step(1, 0, 0, 0, 1);
      chk("ovf_clr", 32'(ovf), 32'd0);

      // Full with write and read together: read wins, write rejected
      step(1, 1, 32'hBAD0_0001, 1, 0);
      chk("full_both_usedw", 32'(usedw), 32'd15);
      chk("full_both_ovf",   32'(ovf),   32'd1);
      step(1, 0, 0, 0, 1);

      // Drain remaining 15 in order
      for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 0);
      chk("drained_empty", 32'(rdempty), 32'd1);

      // Empty with write and read together
      step(1, 1, 32'h1234_5678, 1, 0);
      chk("udf_set",    32'(udf),   32'd1);
      chk("udf_usedw",  32'(usedw), 32'd1);
      chk("udf_rdata",  rdata,      32'h1234_5678);
      step(1, 0, 0, 1, 0);
      // New underflow together with clear keeps the flag set
      step(1, 0, 0, 1, 1);
      chk("udf_clr_vs_new", 32'(udf), 32'd1);
      step(1, 0, 0, 0, 1);
      chk("udf_clr", 32'(udf), 32'd0);

      // Streaming with rdack = ~rdempty; pointers wrap twice
      max_used_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 32'(i), !rdempty, 0);
         if (usedw > 5'd1) max_used_ok = 1'b0;
      end
      step(1, 0, 0, !rdempty, 0);
      chk("stream_usedw_le1", 32'(max_used_ok), 32'd1);
      chk("stream_no_udf",    32'(udf),         32'd0);
      chk("stream_no_ovf",    32'(ovf),         32'd0);

      // Mid-operation reset with a concurrent write
      for (int i = 0; i < 5; i++) step(1, 1, 32'h0000_0100 + 32'(i), 0, 0);
      step(0, 1, 32'h5555_5555, 0, 0);
      chk("mrst_usedw",   32'(usedw),   32'd0);
      chk("mrst_rdempty", 32'(rdempty), 32'd1);
      step(1, 1, 32'hA5A5_A5A5, 0, 0);
      chk("mrst_head", rdata, 32'hA5A5_A5A5);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
